// File: rtl/math_stream_driver.sv
// math_stream_driver: feeds operand pairs into a free-running registered math
// engine, tracks in-flight results with credits and collects each result plus
// the engine change counter into a show-ahead output FIFO.
module math_stream_driver #(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 8,
  parameter int          LAT      = 1,
  parameter logic [15:0] STAT_SIG = 16'hF00D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_ain,
  input  logic [DATA_W-1:0]        s_bin,
  output logic [DATA_W-1:0]        eng_ain,
  output logic [DATA_W-1:0]        eng_bin,
  input  logic [DATA_W-1:0]        eng_result,
  input  logic [31:0]              eng_statistic,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_result,
  output logic [15:0]              m_count,
  input  logic                     flush,
  output logic                     busy,
  output logic                     sig_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [LAT:0]           pipe_r;
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [AW:0]            level_r;
  logic [DATA_W+15:0]     mem_r [DEPTH];
  logic                   sig_err_r;
  logic [DATA_W-1:0]      ain_r;
  logic [DATA_W-1:0]      bin_r;
  logic [CW-1:0]          inflight_s;
  logic [CW-1:0]          credit_s;
  logic                   accept_s;
  logic                   wr_en_s;
  logic                   rd_en_s;

  // Number of results still travelling through the engine.
  function automatic logic [CW-1:0] popcount(input logic [LAT:0] v);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 0; i <= LAT; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  assign inflight_s = popcount(pipe_r);
  assign credit_s   = {1'b0, level_r} + inflight_s;
  assign s_ready    = (state_r == RUN) && (credit_s < DEPTH_C);
  assign accept_s   = s_valid && s_ready;
  assign wr_en_s    = pipe_r[LAT];
  // The CLEAR cycle hides the stale contents so no pop handshake can happen.
  assign m_valid    = (|level_r) && (state_r != CLEAR);
  assign rd_en_s    = m_valid && m_ready;
  assign m_result   = mem_r[rd_ptr_r][DATA_W+15:16];
  assign m_count    = mem_r[rd_ptr_r][15:0];
  assign busy       = (state_r != RUN) || (inflight_s != {CW{1'b0}});
  assign sig_err    = sig_err_r;
  assign level      = level_r;
  assign eng_ain    = ain_r;
  assign eng_bin    = bin_r;

  // Next-state logic for the flush sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (flush) state_next_s = DRAIN;
        else       state_next_s = RUN;
      end
      DRAIN: begin
        if (inflight_s == {CW{1'b0}}) state_next_s = CLEAR;
        else                          state_next_s = DRAIN;
      end
      CLEAR:   state_next_s = RUN;
      default: state_next_s = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= RUN;
    else     state_r <= state_next_s;
  end

  // Engine operands: load on accept, otherwise hold so the engine never sees a spurious change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ain_r <= {DATA_W{1'b0}};
      bin_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      ain_r <= s_ain;
      bin_r <= s_bin;
    end
  end

  // In-flight pipe: top bit marks the cycle the engine result for an accept is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_r <= {(LAT+1){1'b0}};
    else     pipe_r <= {pipe_r[LAT-1:0], accept_s};
  end

  // FIFO storage: result and change counter captured together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {(DATA_W+16){1'b0}};
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {eng_result, eng_statistic[15:0]};
    end
  end

  // FIFO pointers and occupancy; CLEAR discards everything and ignores pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else if (state_r == CLEAR) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky flag: a result arrived from an engine with the wrong signature.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               sig_err_r <= 1'b0;
    else if (wr_en_s && (eng_statistic[31:16] != STAT_SIG)) sig_err_r <= 1'b1;
  end

endmodule

// File: tb/tb_math_stream_driver.sv
// Bench for math_stream_driver: a max() engine with a change counter, a
// queue-based reference model, a per-cycle compare and directed scenarios
// followed by randomized traffic.
module tb_math_stream_driver;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 8;
  localparam int          LAT      = 1;
  localparam logic [15:0] STAT_SIG = 16'hF00D;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_ain = '0;
  logic [DATA_W-1:0] s_bin = '0;
  logic [DATA_W-1:0] eng_ain;
  logic [DATA_W-1:0] eng_bin;
  logic [DATA_W-1:0] eng_result;
  logic [31:0]       eng_statistic;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_result;
  logic [15:0]       m_count;
  logic              flush = 1'b0;
  logic              busy;
  logic              sig_err;
  logic [3:0]        level;

  int checks = 0;
  int errors = 0;

  math_stream_driver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LAT(LAT), .STAT_SIG(STAT_SIG)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_ain(s_ain), .s_bin(s_bin),
    .eng_ain(eng_ain), .eng_bin(eng_bin), .eng_result(eng_result), .eng_statistic(eng_statistic),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_count(m_count),
    .flush(flush), .busy(busy), .sig_err(sig_err), .level(level)
  );

  always #5 clk = ~clk;

  // Engine: result = max(ain, bin) one cycle later, counter counts result changes.
  logic [DATA_W-1:0] eng_res;
  logic [15:0]       eng_cnt;
  logic [15:0]       sig_hi = STAT_SIG;
  wire  [DATA_W-1:0] eng_max = (eng_ain > eng_bin) ? eng_ain : eng_bin;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_res <= '0;
      eng_cnt <= '0;
    end else if (eng_max != eng_res) begin
      eng_res <= eng_max;
      eng_cnt <= eng_cnt + 16'd1;
    end
  end
  assign eng_result    = eng_res;
  assign eng_statistic = {sig_hi, eng_cnt};

  // Reference model: results waiting in the engine and results stored in the FIFO.
  typedef struct { logic [31:0] res; logic [15:0] cnt; } fent_t;
  typedef struct { int cyc; logic [31:0] res; } pent_t;
  fent_t       fifo_q[$];
  pent_t       pend_q[$];
  int          mode = 0;      // 0 run, 1 draining, 2 clearing
  int          now = 0;
  logic [31:0] prev_res = '0;
  logic [15:0] cnt_m = '0;
  logic        exp_sig = 1'b0;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q.delete(); pend_q.delete();
      mode = 0; prev_res = '0; cnt_m = '0; exp_sig = 1'b0; last_a = '0; last_b = '0;
    end else begin
      bit acc;
      int pre_pend;
      int pre_mode;
      acc      = s_valid && (mode == 0) && (fifo_q.size() + pend_q.size() < DEPTH);
      pre_pend = pend_q.size();
      pre_mode = mode;
      if (pre_mode == 2) begin
        fifo_q.delete();
        mode = 0;
      end else begin
        if (m_ready && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (pend_q.size() > 0 && pend_q[0].cyc + LAT + 1 == now) begin
          fent_t e;
          if (pend_q[0].res != prev_res) begin
            prev_res = pend_q[0].res;
            cnt_m    = cnt_m + 16'd1;
          end
          e.res = pend_q[0].res;
          e.cnt = cnt_m;
          fifo_q.push_back(e);
          if (sig_hi != STAT_SIG) exp_sig = 1'b1;
          void'(pend_q.pop_front());
        end
        if (pre_mode == 0 && flush)            mode = 1;
        else if (pre_mode == 1 && pre_pend == 0) mode = 2;
      end
      if (acc) begin
        pent_t p;
        p.cyc  = now;
        p.res  = (s_ain > s_bin) ? s_ain : s_bin;
        pend_q.push_back(p);
        last_a = s_ain;
        last_b = s_bin;
      end
      now++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      bit exp_valid;
      exp_valid = (fifo_q.size() > 0) && (mode != 2);
      chk("s_ready", s_ready, (mode == 0) && (fifo_q.size() + pend_q.size() < DEPTH));
      chk("m_valid", m_valid, exp_valid);
      if (exp_valid) begin
        chk("m_result", m_result, fifo_q[0].res);
        chk("m_count", m_count, fifo_q[0].cnt);
      end
      chk("level", level, fifo_q.size());
      chk("busy", busy, (mode != 0) || (pend_q.size() != 0));
      chk("sig_err", sig_err, exp_sig);
      chk("eng_ain", eng_ain, last_a);
      chk("eng_bin", eng_bin, last_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int idx;
    int n;
    int seen;
    int bubbles;
    logic [31:0] got[$];
    bit acc;

    // Reset state
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sig_err", sig_err, 0);
    chk("rst_eng_ain", eng_ain, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk); #3 rst = 1'b0;

    // Single pair: max(5,9)=9, first change so count 1
    tick();
    s_valid = 1; s_ain = 5; s_bin = 9;
    tick();
    s_valid = 0;
    chk("sp_valid_k0", m_valid, 0);
    tick();
    chk("sp_valid_k1", m_valid, 0);
    tick();
    chk("sp_valid_k2", m_valid, 1);
    chk("sp_result", m_result, 9);
    chk("sp_count", m_count, 1);
    chk("sp_level", level, 1);
    m_ready = 1;
    tick();
    m_ready = 0;
    chk("sp_level_pop", level, 0);
    chk("sp_busy_pop", busy, 0);

    // Back-pressure: 10 pairs (i, 20-i) into an 8-deep FIFO
    idx = 0;
    s_valid = 1; s_ain = 0; s_bin = 20;
    for (int c = 0; c < 20; c++) begin
      acc = s_valid && s_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 10) begin s_ain = idx; s_bin = 20 - idx; end
        else s_valid = 0;
      end
    end
    chk("bp_accepted", idx, 8);
    chk("bp_ready", s_ready, 0);
    chk("bp_level", level, 8);
    m_ready = 1;
    for (int c = 0; c < 40 && got.size() < 10; c++) begin
      acc = s_valid && s_ready;
      if (m_valid && m_ready) got.push_back(m_result);
      tick();
      if (acc) begin
        idx++;
        if (idx < 10) begin s_ain = idx; s_bin = 20 - idx; end
        else s_valid = 0;
      end
    end
    m_ready = 0;
    chk("bp_popped", got.size(), 10);
    for (int j = 0; j < 10 && j < got.size(); j++) chk("bp_order", got[j], 20 - j);

    // Full-rate streaming: no bubble once results start
    m_ready = 1; s_valid = 1; s_ain = $urandom; s_bin = $urandom;
    n = 0; seen = 0; bubbles = 0;
    for (int c = 0; c < 24; c++) begin
      acc = s_valid && s_ready;
      if (m_valid) seen++;
      else if (seen > 0 && seen < 16) bubbles++;
      tick();
      if (acc) begin
        n++;
        if (n == 16) s_valid = 0;
        else begin s_ain = $urandom; s_bin = $urandom; end
      end
    end
    chk("st_bubbles", bubbles, 0);
    chk("st_seen", seen, 16);
    m_ready = 0;

    // Flush with 3 stored and 2 in flight
    s_valid = 1;
    for (int j = 0; j < 5; j++) begin
      s_ain = 100 + j; s_bin = j;
      tick();
    end
    s_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    chk("fl_ready_next", s_ready, 0);
    chk("fl_busy", busy, 1);
    tick();
    chk("fl_level_drained", level, 5);
    tick();
    chk("fl_clear_valid", m_valid, 0);
    tick();
    chk("fl_level", level, 0);
    chk("fl_m_valid", m_valid, 0);
    chk("fl_busy_end", busy, 0);
    chk("fl_ready_end", s_ready, 1);

    // Signature mismatch is sticky
    sig_hi = 16'hBEEF;
    s_valid = 1; s_ain = 3; s_bin = 4;
    tick();
    s_valid = 0;
    tick(); tick();
    chk("sg_set", sig_err, 1);
    sig_hi = STAT_SIG;
    s_valid = 1;
    for (int j = 0; j < 3; j++) begin s_ain = 50 + j; s_bin = 1; tick(); end
    s_valid = 0;
    repeat (4) tick();
    chk("sg_sticky", sig_err, 1);
    m_ready = 1;
    repeat (6) tick();
    m_ready = 0;

    // Reset between accept and write
    s_valid = 1; s_ain = 77; s_bin = 66;
    tick();
    s_valid = 0;
    #1 rst = 1;
    #1;
    chk("rs_m_valid", m_valid, 0);
    chk("rs_level", level, 0);
    chk("rs_eng_ain", eng_ain, 0);
    chk("rs_eng_bin", eng_bin, 0);
    chk("rs_sig_err", sig_err, 0);
    @(posedge clk); @(posedge clk); #3 rst = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rs_no_stale", m_valid, 0);
    end

    // Randomized traffic with occasional flush
    for (int c = 0; c < 800; c++) begin
      s_valid = ($urandom % 4) != 0;
      if ($urandom % 2) begin s_ain = $urandom_range(0, 7); s_bin = $urandom_range(0, 7); end
      else begin s_ain = $urandom; s_bin = $urandom; end
      m_ready = ($urandom % 3) != 0;
      flush   = ($urandom % 50) == 0;
      tick();
    end
    s_valid = 0; flush = 0; m_ready = 1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
